text_box_ctl: RTL and testbench

Pixel-domain sequencer that drives the character-rectangle text ROM and the font ROM for one on-screen text box (score, ammo, "GAME OVER"). From the incoming VGA timing it computes the character cell (char_x, char_y) and glyph row (char_line). It realigns the timing and RGB stream to the ROM latency and overlays the returned font bits in a fixed colour. It also blinks the box at a frame-counted rate. It sits in the draw chain between the background/duck layers and the VGA output.

---
 rtl/text_pkg.sv | 13 +
 rtl/delay.sv | 29 ++
 rtl/text_box_ctl.sv | 136 +++++++++++++
 tb/tb_text_box_ctl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared types and helpers for the text-box draw stage.
package text_pkg;
    localparam int RGB_W = 12;
    localparam int VGA_W = 11;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t TEXT_RGB_DEF = 12'hFFF;

    function automatic int box_extent(input int size, input int char_w);
        return size * char_w;
    endfunction
endpackage

// File: rtl/delay.sv
// Generic N-stage register delay with synchronous reset; CLK_DEL=0 is a wire.
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    generate
        if (CLK_DEL == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [CLK_DEL-1:0][WIDTH-1:0] pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= din;
                    for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign dout = pipe[CLK_DEL-1];
        end
    endgenerate
endmodule

// File: rtl/text_box_ctl.sv
// Text-box sequencer: computes text/font ROM addresses from VGA timing, realigns
// the pixel stream to the ROM latency and overlays glyph bits with optional blink.
module text_box_ctl
    import text_pkg::*;
#(
    parameter int   BOX_X        = 64,
    parameter int   BOX_Y        = 32,
    parameter int   SIZE_X       = 16,
    parameter int   SIZE_Y       = 4,
    parameter int   CHAR_W       = 8,
    parameter int   CHAR_H       = 16,
    parameter int   ROM_LAT      = 2,
    parameter rgb_t TEXT_RGB     = TEXT_RGB_DEF,
    parameter int   BLINK_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [VGA_W-1:0]          hcount_in,
    input  logic [VGA_W-1:0]          vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      hblnk_in,
    input  logic                      vblnk_in,
    input  logic [RGB_W-1:0]          rgb_in,
    input  logic                      en,
    input  logic                      blink_en,
    input  logic [7:0]                char_pixels,
    output logic [$clog2(SIZE_X)-1:0] char_x,
    output logic [$clog2(SIZE_Y)-1:0] char_y,
    output logic [$clog2(CHAR_H)-1:0] char_line,
    output logic [VGA_W-1:0]          hcount_out,
    output logic [VGA_W-1:0]          vcount_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      hblnk_out,
    output logic                      vblnk_out,
    output logic [RGB_W-1:0]          rgb_out
);
    localparam int CXW  = $clog2(SIZE_X);
    localparam int CYW  = $clog2(SIZE_Y);
    localparam int CLW  = $clog2(CHAR_H);
    localparam int CWB  = $clog2(CHAR_W);
    localparam int CHB  = $clog2(CHAR_H);
    localparam int EXT_X = box_extent(SIZE_X, CHAR_W);
    localparam int EXT_Y = box_extent(SIZE_Y, CHAR_H);
    localparam int BCW  = $clog2(BLINK_FRAMES) + 1;
    localparam int DW   = 1 + CWB + 4 + 2 * VGA_W + RGB_W;

    logic [VGA_W-1:0] dx, dy;
    logic             in_box_n;
    logic [CWB-1:0]   bit_idx_n;

    // dx/dy may wrap outside the box; addresses are only taken from them when in_box.
    assign dx        = hcount_in - VGA_W'(BOX_X);
    assign dy        = vcount_in - VGA_W'(BOX_Y);
    assign in_box_n  = (int'(hcount_in) >= BOX_X) && (int'(hcount_in) < BOX_X + EXT_X) &&
                       (int'(vcount_in) >= BOX_Y) && (int'(vcount_in) < BOX_Y + EXT_Y);
    assign bit_idx_n = CWB'(CHAR_W - 1) - dx[CWB-1:0];

    always_ff @(posedge clk) begin
        if (rst || !in_box_n) begin
            char_x    <= '0;
            char_y    <= '0;
            char_line <= '0;
        end else begin
            char_x    <= CXW'(dx >> CWB);
            char_y    <= CYW'(dy >> CHB);
            char_line <= dy[CLW-1:0];
        end
    end

    // Stage A plus ROM_LAT cycles of ROM latency, so the bundle meets char_pixels.
    logic [DW-1:0]      bus_in, bus_d;
    logic               in_box_d;
    logic [CWB-1:0]     bit_idx_d;
    logic               hsync_d, vsync_d, hblnk_d, vblnk_d;
    logic [VGA_W-1:0]   hcount_d, vcount_d;
    logic [RGB_W-1:0]   rgb_d;

    assign bus_in = {in_box_n, bit_idx_n, hsync_in, vsync_in, hblnk_in, vblnk_in,
                     hcount_in, vcount_in, rgb_in};
    assign {in_box_d, bit_idx_d, hsync_d, vsync_d, hblnk_d, vblnk_d,
            hcount_d, vcount_d, rgb_d} = bus_d;

    delay #(.WIDTH(DW), .CLK_DEL(ROM_LAT + 1)) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (bus_in),
        .dout (bus_d)
    );

    logic           vblnk_prev;
    logic [BCW-1:0] blink_cnt;
    logic           visible;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            blink_cnt  <= '0;
            visible    <= 1'b1;
        end else begin
            vblnk_prev <= vblnk_in;
            if (!blink_en) begin
                blink_cnt <= '0;
                visible   <= 1'b1;
            end else if (vblnk_in && !vblnk_prev) begin
                if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    visible   <= !visible;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_d;
            vcount_out <= vcount_d;
            hsync_out  <= hsync_d;
            vsync_out  <= vsync_d;
            hblnk_out  <= hblnk_d;
            vblnk_out  <= vblnk_d;
            rgb_out    <= (en && visible && in_box_d && char_pixels[bit_idx_d]) ? TEXT_RGB : rgb_d;
        end
    end
endmodule

// File: tb/tb_text_box_ctl.sv
// Scoreboard bench for text_box_ctl: directed pixels, boundaries, blink and en=0.
module tb_text_box_ctl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
    logic [11:0] rgb_in = '0;
    logic        en = 1'b1, blink_en = 1'b0;
    logic [7:0]  char_pixels;
    logic [3:0]  char_x;
    logic [1:0]  char_y;
    logic [3:0]  char_line;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    text_box_ctl #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .en(en), .blink_en(blink_en), .char_pixels(char_pixels),
        .char_x(char_x), .char_y(char_y), .char_line(char_line),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic [10:0] h;
        logic [10:0] v;
        logic [3:0]  tim;
    } exp_t;

    typedef struct packed {
        logic [3:0] x;
        logic [1:0] y;
        logic [3:0] l;
    } addr_t;

    exp_t  exp_q[$];
    addr_t addr_q[$];
    exp_t  e;
    addr_t a;
    int    checks = 0, errors = 0;

    // Stimulus-side tracking: vld_pipe marks which output cycles carry a vector,
    // cp_pipe plays the ROM by presenting each vector's font row at the right cycle.
    logic           cur_vld = 1'b0, cur_achk = 1'b0;
    logic [7:0]     cur_cp = '0;
    logic [3:0]     vld_pipe;
    logic           achk_pipe;
    logic [2:0][7:0] cp_pipe;

    always @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            achk_pipe <= 1'b0;
            cp_pipe   <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[2:0], cur_vld};
            achk_pipe <= cur_achk;
            cp_pipe   <= {cp_pipe[1:0], cur_cp};
        end
    end

    assign char_pixels = cp_pipe[2];

    always @(negedge clk) begin
        if (!rst) begin
            if (achk_pipe) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL addr_underflow: no expected address queued");
                end else begin
                    a = addr_q.pop_front();
                    if ({char_x, char_y, char_line} !== a) begin
                        errors++;
                        $display("FAIL addr: got x=%0d y=%0d line=%0d, want x=%0d y=%0d line=%0d",
                                 char_x, char_y, char_line, a.x, a.y, a.l);
                    end
                end
            end
            if (vld_pipe[3]) begin
                checks += 2;
                if (exp_q.size() == 0) begin
                    errors += 2;
                    $display("FAIL out_underflow: no expected output queued");
                end else begin
                    e = exp_q.pop_front();
                    if (rgb_out !== e.rgb) begin
                        errors++;
                        $display("FAIL rgb (h=%0d v=%0d): got %h, want %h", e.h, e.v, rgb_out, e.rgb);
                    end
                    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
                        {e.h, e.v, e.tim}) begin
                        errors++;
                        $display("FAIL timing: got h=%0d v=%0d t=%b, want h=%0d v=%0d t=%b",
                                 hcount_out, vcount_out,
                                 {hsync_out, vsync_out, hblnk_out, vblnk_out}, e.h, e.v, e.tim);
                    end
                end
            end else begin
                checks++;
                if (rgb_out !== 12'h0 || hcount_out !== 11'h0 || vcount_out !== 11'h0) begin
                    errors++;
                    $display("FAIL flush: got rgb=%h h=%0d v=%0d, want all 0", rgb_out, hcount_out, vcount_out);
                end
            end
        end
    end

    task automatic vec(input logic [10:0] h, input logic [10:0] v, input logic [3:0] tim,
                       input logic [11:0] rgb, input logic [7:0] cp, input logic [11:0] exp_rgb,
                       input logic achk, input logic [3:0] ex, input logic [1:0] ey,
                       input logic [3:0] el);
        @(posedge clk);
        #1;
        hcount_in = h;
        vcount_in = v;
        {hsync_in, vsync_in, hblnk_in, vblnk_in} = tim;
        rgb_in   = rgb;
        cur_cp   = cp;
        cur_vld  = 1'b1;
        cur_achk = achk;
        exp_q.push_back('{rgb: exp_rgb, h: h, v: v, tim: tim});
        if (achk) addr_q.push_back('{x: ex, y: ey, l: el});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) vec(11'd0, 11'd0, 4'b0000, 12'h0A5, 8'h00, 12'h0A5, 1'b0, 4'd0, 2'd0, 4'd0);
    endtask

    int vis_pat[6] = '{1, 0, 0, 1, 1, 0};

    initial begin
        // Reset with random inputs: all outputs must read 0.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            hcount_in = 11'($urandom);
            vcount_in = 11'($urandom);
            {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
            rgb_in = 12'($urandom);
            cur_cp = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({char_x, char_y, char_line, hcount_out, vcount_out, hsync_out, vsync_out,
                 hblnk_out, vblnk_out, rgb_out} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got rgb=%h h=%0d v=%0d x=%0d, want all 0",
                         rgb_out, hcount_out, vcount_out, char_x);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        hcount_in = '0; vcount_in = '0; rgb_in = '0; cur_cp = '0;
        {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b0000;

        // Addressing and compositing inside the box.
        vec(11'd93,  11'd71, 4'b1000, 12'h123, 8'b0000_0100, 12'hFFF, 1'b1, 4'd3,  2'd2, 4'd7);
        vec(11'd93,  11'd71, 4'b0100, 12'h123, 8'h00,        12'h123, 1'b1, 4'd3,  2'd2, 4'd7);
        vec(11'd93,  11'd71, 4'b0010, 12'h123, 8'b0000_1000, 12'h123, 1'b0, 4'd0,  2'd0, 4'd0);
        // Left/right/top/bottom edges.
        vec(11'd63,  11'd71, 4'b0000, 12'h0AB, 8'hFF,        12'h0AB, 1'b1, 4'd0,  2'd0, 4'd0);
        vec(11'd192, 11'd71, 4'b1111, 12'h0CD, 8'hFF,        12'h0CD, 1'b1, 4'd0,  2'd0, 4'd0);
        vec(11'd191, 11'd71, 4'b0000, 12'h456, 8'h01,        12'hFFF, 1'b1, 4'd15, 2'd2, 4'd7);
        vec(11'd191, 11'd71, 4'b0000, 12'h456, 8'h80,        12'h456, 1'b0, 4'd0,  2'd0, 4'd0);
        vec(11'd64,  11'd32, 4'b0001, 12'h111, 8'h80,        12'hFFF, 1'b1, 4'd0,  2'd0, 4'd0);
        vec(11'd64,  11'd31, 4'b0000, 12'h222, 8'hFF,        12'h222, 1'b1, 4'd0,  2'd0, 4'd0);
        vec(11'd64,  11'd96, 4'b0000, 12'h333, 8'hFF,        12'h333, 1'b1, 4'd0,  2'd0, 4'd0);
        vec(11'd100, 11'd95, 4'b0000, 12'h444, 8'h08,        12'hFFF, 1'b1, 4'd4,  2'd3, 4'd15);
        idle(4);

        // Blink with BLINK_FRAMES=2: one vblnk rise then a glyph pixel per frame.
        blink_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            vec(11'd0, 11'd0, 4'b0001, 12'h000, 8'h00, 12'h000, 1'b0, 4'd0, 2'd0, 4'd0);
            idle(1);
            vec(11'd93, 11'd71, 4'b0000, 12'h123, 8'h04,
                (vis_pat[f] != 0) ? 12'hFFF : 12'h123, 1'b0, 4'd0, 2'd0, 4'd0);
            idle(4);
        end
        // Disabling blink restores visibility on the next cycle.
        blink_en = 1'b0;
        vec(11'd93, 11'd71, 4'b0000, 12'h123, 8'h04, 12'hFFF, 1'b0, 4'd0, 2'd0, 4'd0);
        idle(4);

        // en=0: pure pass-through, addressing still runs.
        en = 1'b0;
        vec(11'd93,  11'd71, 4'b1010, 12'h123, 8'h04, 12'h123, 1'b1, 4'd3,  2'd2, 4'd7);
        vec(11'd191, 11'd71, 4'b0101, 12'h456, 8'hFF, 12'h456, 1'b1, 4'd15, 2'd2, 4'd7);
        idle(4);

        @(posedge clk);
        #1;
        cur_vld = 1'b0;
        cur_achk = 1'b0;
        cur_cp = '0;
        hcount_in = '0; vcount_in = '0; rgb_in = '0;
        {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b0000;
        for (int i = 0; i < 30 && (exp_q.size() != 0 || addr_q.size() != 0); i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs and %0d addresses still pending, want 0",
                     exp_q.size(), addr_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
